// File: rtl/stack_pkg.sv
// Shared types and constants for the stack push/pop unit.
package stack_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned RW_W             = 4;
  localparam int unsigned STACK_WORD_BYTES = 4;

  localparam logic [RW_W-1:0] RW_STACK_ADDR = 4'h5;
  localparam logic [RW_W-1:0] RW_NONE       = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEM   = 3'd1,
    ST_SPUPD = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Request context captured at acceptance and carried through the sequence.
  typedef struct packed {
    logic            push;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] new_sp;
    logic [XLEN-1:0] rdata;
  } req_ctx_t;

  // Full registered output image of the unit.
  typedef struct packed {
    logic            cmd_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic [RW_W-1:0] rw;
    logic [XLEN-1:0] write_data;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
  } unit_out_t;

  // One word step of the stack pointer; stack grows downwards.
  function automatic logic [XLEN-1:0] sp_step(input logic [XLEN-1:0] sp, input logic down);
    return down ? sp - XLEN'(STACK_WORD_BYTES) : sp + XLEN'(STACK_WORD_BYTES);
  endfunction

endpackage

// File: rtl/stack_bound_check.sv
// Combinational stack bound check: flags a push below the limit or a pop above the base.
module stack_bound_check
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = 32'h0000_0999,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic [31:0] stack_addr,
  input  logic        push,
  output logic        violation
);

  logic [XLEN-1:0] push_floor;
  logic [XLEN-1:0] pop_top;

  assign push_floor = STACK_LIMIT + XLEN'(STACK_WORD_BYTES);
  assign pop_top    = sp_step(stack_addr, 1'b0);
  assign violation  = push ? (stack_addr < push_floor) : (pop_top > STACK_BASE);

endmodule

// File: rtl/stack_push_pop_unit.sv
// Stack push/pop sequencer: memory access, SP register update, then one-cycle response.
// Define STACK_BOUND_CHECK_EN to enable overflow/underflow detection (ERR path).
module stack_push_pop_unit
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = 32'h0000_0999,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
  input  logic        clock_4,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_push,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic [31:0] stack_addr,
  output logic [3:0]  read_or_write,
  output logic [31:0] write_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  if (STACK_LIMIT > STACK_BASE) begin : g_bad_cfg
    $error("stack_push_pop_unit: STACK_LIMIT above STACK_BASE");
  end

  state_e    state_q, state_d;
  req_ctx_t  ctx_q, ctx_d;
  unit_out_t out_q, out_d;
  logic      viol_c;

`ifdef STACK_BOUND_CHECK_EN
  stack_bound_check #(
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bound_check (
    .stack_addr (stack_addr),
    .push       (cmd_push),
    .violation  (viol_c)
  );
`else
  assign viol_c = 1'b0;
`endif

  // Next state, context capture, and output image for the upcoming state.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    out_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ctx_d.push   = cmd_push;
          ctx_d.data   = cmd_data;
          ctx_d.target = cmd_push ? sp_step(stack_addr, 1'b1) : stack_addr;
          ctx_d.new_sp = sp_step(stack_addr, cmd_push);
          ctx_d.rdata  = '0;
          state_d      = viol_c ? ST_ERR : ST_MEM;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (!ctx_q.push) ctx_d.rdata = mem_rdata;
          state_d = ST_SPUPD;
        end
      end
      ST_SPUPD: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are a pure function of the state being entered, so registering them keeps Moore timing.
    out_d.rw = RW_NONE;
    unique case (state_d)
      ST_IDLE:  out_d.cmd_ready = 1'b1;
      ST_MEM: begin
        out_d.mem_req   = 1'b1;
        out_d.mem_we    = ctx_d.push;
        out_d.mem_addr  = ctx_d.target;
        out_d.mem_wdata = ctx_d.data;
      end
      ST_SPUPD: begin
        out_d.rw         = RW_STACK_ADDR;
        out_d.write_data = ctx_d.new_sp;
      end
      ST_DONE: begin
        out_d.rsp_valid = 1'b1;
        out_d.rsp_data  = ctx_d.rdata;
      end
      ST_ERR:   out_d.rsp_valid = 1'b1;
      default:  out_d.cmd_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clock_4 or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      ctx_q           <= '0;
      out_q           <= '0;
      out_q.cmd_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      out_q   <= out_d;
    end
  end

`ifdef STACK_BOUND_CHECK_EN
  logic rsp_err_q;

  always_ff @(posedge clock_4 or negedge reset) begin
    if (!reset) rsp_err_q <= 1'b0;
    else        rsp_err_q <= (state_d == ST_ERR);
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready     = out_q.cmd_ready;
  assign rsp_valid     = out_q.rsp_valid;
  assign rsp_data      = out_q.rsp_data;
  assign read_or_write = out_q.rw;
  assign write_data    = out_q.write_data;
  assign mem_req       = out_q.mem_req;
  assign mem_we        = out_q.mem_we;
  assign mem_addr      = out_q.mem_addr;
  assign mem_wdata     = out_q.mem_wdata;

endmodule

// File: tb/tb_stack_push_pop_unit.sv
// Directed scoreboard bench for stack_push_pop_unit; bench plays SP register and memory.
module tb_stack_push_pop_unit;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] lat;
  } exp_t;

  logic        clock_4;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_push;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] stack_addr;
  logic [3:0]  read_or_write;
  logic [31:0] write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  int last_acc = 0;
  int acc_gap  = 0;

  exp_t        exp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  stack_push_pop_unit dut (
    .clock_4       (clock_4),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_push      (cmd_push),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .stack_addr    (stack_addr),
    .read_or_write (read_or_write),
    .write_data    (write_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
  );

  initial clock_4 = 1'b0;
  always #5 clock_4 = ~clock_4;

  always @(posedge clock_4) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_viol(input logic [31:0] sp, input logic push);
    logic v;
    v = push ? (sp < 32'h0000_0804) : ((sp + 32'd4) > 32'h0000_0999);
`ifndef STACK_BOUND_CHECK_EN
    v = 1'b0;
`endif
    return v;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (32'hA5A5_0000 ^ a);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_rw"}, read_or_write, 4'h0);
  endtask

  // One complete request starting from an IDLE negedge; returns at the response cycle.
  task automatic do_cmd(input logic push, input logic [31:0] data, input int wait_cyc, input bit hold);
    logic [31:0] tgt, nsp, rd;
    logic        err, rw_now;
    int          n, mc, rwc;
    exp_t        e, got;
    tgt = push ? stack_addr - 32'd4 : stack_addr;
    nsp = push ? tgt : stack_addr + 32'd4;
    err = model_viol(stack_addr, push);
    rd  = push ? 32'h0 : mem_rd(tgt);
    e.data = err ? 32'h0 : rd;
    e.err  = err;
    e.lat  = err ? 32'd1 : 32'(3 + wait_cyc);
    exp_q.push_back(e);

    chk("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_push  = push;
    cmd_data  = data;
    acc_gap   = cyc_cnt - last_acc;
    last_acc  = cyc_cnt;
    @(negedge clock_4);
    if (!hold) cmd_valid = 1'b0;
    cmd_data = ~data;

    n = 1; mc = 0; rwc = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      chk("busy_ready", cmd_ready, 0);
      if (mem_req === 1'b1) begin
        chk("mem_we", mem_we, push);
        chk("mem_addr", mem_addr, tgt);
        if (push) chk("mem_wdata", mem_wdata, data);
        if (mc == wait_cyc) begin
          mem_ack   = 1'b1;
          mem_rdata = push ? 32'hBAD0_BAD0 : mem_rd(tgt);
          if (push) mem_model[tgt] = data;
        end
        mc++;
      end
      rw_now = (read_or_write === 4'h5);
      if (rw_now) begin
        chk("sp_write_data", write_data, nsp);
        rwc++;
      end
      @(negedge clock_4);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if (rw_now) stack_addr = nsp;
      n++;
    end

    chk("rsp_seen", rsp_valid, 1);
    if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("latency", n, got.lat);
      chk("rsp_data", rsp_data, got.data);
      chk("rsp_err", rsp_err, got.err);
    end
    chk("mem_cycles", mc, err ? 0 : wait_cyc + 1);
    chk("sp_writes", rwc, err ? 0 : 1);
    chk("rsp_mem_req", mem_req, 0);
    chk("rsp_rw", read_or_write, 4'h0);
  endtask

  initial begin
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_push   = 1'b0;
    cmd_data   = 32'h0;
    stack_addr = 32'h0000_0999;
    mem_rdata  = 32'h0;
    mem_ack    = 1'b0;

    repeat (3) @(negedge clock_4);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rw", read_or_write, 4'h0);
    chk("rst_write_data", write_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b1;
    @(negedge clock_4);
    check_idle("post_rst");

    // Push into empty stack, immediate ack.
    do_cmd(1'b1, 32'hDEAD_BEEF, 0, 1'b0);
    chk("push_sp", stack_addr, 32'h0000_0995);
    @(negedge clock_4);

    // Pop with three wait cycles.
    mem_model[32'h0000_0995] = 32'h1234_5678;
    do_cmd(1'b0, 32'h0, 3, 1'b0);
    chk("pop_sp", stack_addr, 32'h0000_0999);
    @(negedge clock_4);

    // Pop from the empty stack.
    do_cmd(1'b0, 32'h0, 0, 1'b0);
    @(negedge clock_4);

    // Push near the limit.
    stack_addr = 32'h0000_0802;
    do_cmd(1'b1, 32'hCAFE_F00D, 1, 1'b0);
    @(negedge clock_4);

    // Push at address zero wraps modulo 2^32.
    stack_addr = 32'h0000_0000;
    do_cmd(1'b1, 32'h0BAD_CAFE, 0, 1'b0);
    @(negedge clock_4);
    do_cmd(1'b0, 32'h0, 2, 1'b0);
    @(negedge clock_4);

    // Stray acks while idle.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock_4);
    check_idle("stray_ack1");
    @(negedge clock_4);
    check_idle("stray_ack2");
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Back-to-back pushes with cmd_valid held high.
    stack_addr = 32'h0000_0900;
    do_cmd(1'b1, 32'h1111_2222, 0, 1'b1);
    @(negedge clock_4);
    do_cmd(1'b1, 32'h3333_4444, 0, 1'b0);
    chk("b2b_gap", acc_gap, 4);
    chk("b2b_sp", stack_addr, 32'h0000_08F8);
    @(negedge clock_4);

    // Reset asserted while the memory request is outstanding.
    cmd_valid = 1'b1;
    cmd_push  = 1'b1;
    cmd_data  = 32'h5555_AAAA;
    @(negedge clock_4);
    cmd_valid = 1'b0;
    chk("mid_mem_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rstmem_mem_req", mem_req, 0);
    chk("rstmem_ready", cmd_ready, 1);
    chk("rstmem_rw", read_or_write, 4'h0);
    @(negedge clock_4);
    chk("rstmem_rw_hold", read_or_write, 4'h0);
    reset = 1'b1;
    @(negedge clock_4);
    check_idle("rstmem_rel1");
    @(negedge clock_4);
    check_idle("rstmem_rel2");
    chk("rstmem_sp", stack_addr, 32'h0000_08F8);

    do_cmd(1'b0, 32'h0, 1, 1'b0);
    chk("final_pop_sp", stack_addr, 32'h0000_08FC);
    @(negedge clock_4);
    check_idle("end");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
